axis_rr_arbiter: RTL
====================

Name: axis_rr_arbiter

Overview:
- Packet-level round-robin arbiter that merges NUM_S AXI4-Stream slave ports onto one master port.
- A grant is held from the first beat of a packet through its tlast beat, so packets are never interleaved.
- Sits upstream of any single-consumer AXIS datapath: DMA write channel, shared FIFO, or shared CDC bridge.
- Exposes the current grant for debug and for downstream routing.

Parameters:
- NUM_S, 4, number of slave ports; 2..16.
- N, 4, tdata width in bytes; tstrb/tkeep are N bits.
- I, 1, tid width.
- D, 1, tdest width.
- U, 1, tuser width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  async active-low reset.
- s_tvalid  in  NUM_S  per-port valid.
- s_tready  out  NUM_S  per-port ready.
- s_tdata  in  NUM_S*8*N  port k occupies bits [k*8N +: 8N].
- s_tstrb  in  NUM_S*N  packed as s_tdata.
- s_tkeep  in  NUM_S*N  packed as s_tdata.
- s_tlast  in  NUM_S  per-port last.
- s_tid  in  NUM_S*I  packed.
- s_tdest  in  NUM_S*D  packed.
- s_tuser  in  NUM_S*U  packed.
- m_tvalid  out  1.
- m_tready  in  1.
- m_tdata  out  8*N.
- m_tstrb  out  N.
- m_tkeep  out  N.
- m_tlast  out  1.
- m_tid  out  I.
- m_tdest  out  D.
- m_tuser  out  U.
- grant  out  $clog2(NUM_S)  index of the granted port; valid while busy=1.
- busy  out  1  a packet is in progress.

Behaviour:
- Clock and reset: single clock aclk. aresetn is asynchronous assert, synchronous deassert (synchronised externally).
- Reset values: state=IDLE, busy=0, grant=0, m_tvalid=0, s_tready=0 on all ports, last-grant pointer=NUM_S-1 (so port 0 wins the first arbitration).
- State IDLE: m_tvalid=0 and all s_tready=0.
  - If any s_tvalid=1, select the first asserted port searching upward from pointer+1, with wrap-around modulo NUM_S.
  - Register the winner into grant and pointer, set busy=1, and go to BUSY.
  - Arbitration latency is 1 cycle: the first beat can transfer no earlier than the cycle after s_tvalid is seen in IDLE.
- State BUSY (combinational datapath): m_tvalid=s_tvalid[grant]; m_t* = slave fields of port grant; s_tready[grant]=m_tready; all other s_tready=0.
  - A beat transfers when m_tvalid && m_tready.
  - A transfer with m_tlast=1 returns the block to IDLE with busy=0.
  - Exactly one bubble cycle separates packets, by design.
- Granted port drops tvalid mid-packet: the grant is held and m_tvalid=0. There is no timeout and no preemption.
- Single-beat packet (tlast on the first beat): legal. Sequence is IDLE, then BUSY for one cycle, then IDLE.
- Only one requester: it is re-granted after every packet, with one bubble between packets.
- Fairness: with all NUM_S ports requesting continuously, grants rotate 0,1,...,NUM_S-1,0. No port waits more than NUM_S-1 packets.
- Request appears during BUSY: not sampled until the next IDLE cycle.
- Reset asserted mid-packet: all outputs return immediately to their reset values and the pointer resets. The partial packet is truncated; the upstream source is responsible for recovery.
- The AXIS rule that tvalid must not drop before handshake is not checked by this block; it is a bench assertion.

Optional Feature:
- Macro: AXIS_RR_ARBITER_OUT_REG_EN.
- Defined: a two-entry skid register slice sits between the mux and the m_* port.
  - All m_* outputs are driven from flops; m_tvalid resets to 0.
  - s_tready[grant] is driven from the skid-not-full flag instead of m_tready.
  - Full throughput is preserved; first-beat latency becomes 2 cycles.
  - The FSM leaves BUSY when tlast is accepted into the slice, not when it leaves the slice.
- Undefined: datapath is combinational as described under Behaviour.

Test Plan:
- Reset, then port 2 sends a 3-beat packet (data 0xA0,0xA1,0xA2) -> grant=2 one cycle after tvalid; m_tdata shows 0xA0..0xA2 on consecutive cycles; tlast on the 3rd beat; busy returns to 0.
- Ports 0-3 each present a 2-beat packet simultaneously, m_tready=1 -> output packet order 0,1,2,3; 11 cycles from first grant to final tlast (4x2 beats plus 3 bubbles); no interleaving.
- Port 1 packet in progress, m_tready toggles 1,0,1,0 -> data held stable while m_tready=0; s_tready[1] mirrors m_tready; s_tready of other ports stays 0.
- Port 0 drops s_tvalid for 5 cycles mid-packet while port 3 requests -> grant stays 0; port 3 is granted only after port 0's tlast.
- aresetn asserted on beat 2 of 4 of a port-2 packet -> m_tvalid=0, busy=0 asynchronously; after release, port 0 wins a simultaneous request from ports 0 and 2.
- With AXIS_RR_ARBITER_OUT_REG_EN: port 0 streams 16 beats with m_tready=1 -> first m_tvalid 2 cycles after request; 16 consecutive beats with no stall.

Source files
------------

// File: rtl/axis_rr_arbiter_if.sv
// Bundle of the merged AXI4-Stream slave ports, the single master port and the
// grant/busy debug outputs of axis_rr_arbiter.
interface axis_rr_arbiter_if #(
    parameter int NUM_S = 4,
    parameter int N     = 4,
    parameter int I     = 1,
    parameter int D     = 1,
    parameter int U     = 1
);
    localparam int GW = $clog2(NUM_S);

    logic [NUM_S-1:0]     s_tvalid;
    logic [NUM_S-1:0]     s_tready;
    logic [NUM_S*8*N-1:0] s_tdata;
    logic [NUM_S*N-1:0]   s_tstrb;
    logic [NUM_S*N-1:0]   s_tkeep;
    logic [NUM_S-1:0]     s_tlast;
    logic [NUM_S*I-1:0]   s_tid;
    logic [NUM_S*D-1:0]   s_tdest;
    logic [NUM_S*U-1:0]   s_tuser;

    logic                 m_tvalid;
    logic                 m_tready;
    logic [8*N-1:0]       m_tdata;
    logic [N-1:0]         m_tstrb;
    logic [N-1:0]         m_tkeep;
    logic                 m_tlast;
    logic [I-1:0]         m_tid;
    logic [D-1:0]         m_tdest;
    logic [U-1:0]         m_tuser;

    logic [GW-1:0]        grant;
    logic                 busy;

    // Arbiter side: consumes the slave streams, drives the merged stream.
    modport master (
        input  s_tvalid, s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser,
        input  m_tready,
        output s_tready,
        output m_tvalid, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser,
        output grant, busy
    );

    // Environment side: sources the slave streams, sinks the merged stream.
    modport slave (
        output s_tvalid, s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser,
        output m_tready,
        input  s_tready,
        input  m_tvalid, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser,
        input  grant, busy
    );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin AXI4-Stream arbiter, NUM_S slaves onto one master.
// Define AXIS_RR_ARBITER_OUT_REG_EN to register the master port through a skid slice.
module axis_rr_arbiter #(
    parameter int NUM_S = 4,
    parameter int N     = 4,
    parameter int I     = 1,
    parameter int D     = 1,
    parameter int U     = 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    axis_rr_arbiter_if.master bus
);
    localparam int GW = $clog2(NUM_S);
    localparam int DW = 8 * N;
    localparam int BW = DW + 2 * N + 1 + I + D + U;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] grant_q, grant_nxt;
    logic [GW-1:0] ptr_q, ptr_nxt;
    logic [GW-1:0] winner, cand;
    logic          found;
    logic [BW-1:0] sel_beat;
    logic          sel_valid, sel_last, sel_ready, accept;

    // First requester strictly after the last-granted port, wrapping modulo NUM_S.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_S; k++) begin
            cand = GW'((int'(ptr_q) + k) % NUM_S);
            if (!found && bus.s_tvalid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        sel_valid = (state == BUSY) && bus.s_tvalid[grant_q];
        sel_last  = bus.s_tlast[grant_q];
        sel_beat  = {bus.s_tdata[grant_q*DW +: DW],
                     bus.s_tstrb[grant_q*N +: N],
                     bus.s_tkeep[grant_q*N +: N],
                     bus.s_tlast[grant_q],
                     bus.s_tid[grant_q*I +: I],
                     bus.s_tdest[grant_q*D +: D],
                     bus.s_tuser[grant_q*U +: U]};
    end

    assign accept = sel_valid && sel_ready;

    always_comb begin
        bus.s_tready = '0;
        if (state == BUSY) begin
            bus.s_tready[grant_q] = sel_ready;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr_q   <= GW'(NUM_S - 1);
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            ptr_q   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        ptr_nxt   = ptr_q;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BUSY;
                    grant_nxt = winner;
                    ptr_nxt   = winner;
                end
            end
            BUSY: begin
                if (accept && sel_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.grant = grant_q;
    assign bus.busy  = (state == BUSY);

`ifdef AXIS_RR_ARBITER_OUT_REG_EN
    logic          out_valid, skid_valid;
    logic [BW-1:0] out_beat, skid_beat;

    // Upstream only sees ready while the skid entry is free, so a stall on
    // m_tready never loses the beat accepted in the same cycle.
    assign sel_ready = !skid_valid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_beat   <= '0;
            skid_beat  <= '0;
        end else if (!out_valid || bus.m_tready) begin
            if (skid_valid) begin
                out_beat   <= skid_beat;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) begin
                    out_beat <= sel_beat;
                end
            end
        end else if (accept) begin
            skid_beat  <= sel_beat;
            skid_valid <= 1'b1;
        end
    end

    assign bus.m_tvalid = out_valid;
    assign {bus.m_tdata, bus.m_tstrb, bus.m_tkeep, bus.m_tlast,
            bus.m_tid, bus.m_tdest, bus.m_tuser} = out_beat;
`else
    assign sel_ready    = bus.m_tready;
    assign bus.m_tvalid = sel_valid;
    assign {bus.m_tdata, bus.m_tstrb, bus.m_tkeep, bus.m_tlast,
            bus.m_tid, bus.m_tdest, bus.m_tuser} = sel_beat;
`endif

endmodule
